// File: rtl/hs_bus_amba_axis_w2mif_skid_if.sv
// AXI-Stream interface bundle shared by wire-level adapters and interface-based fabric.
// Master drives payload and valid; slave drives tready.
interface hs_bus_amba_axis_if #(
    parameter int TDATA_WIDTH = 8,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TSTRB_WIDTH = TDATA_WIDTH / 8,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8
) ();
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic [TSTRB_WIDTH-1:0] tstrb;
    logic [TKEEP_WIDTH-1:0] tkeep;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   twakeup;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
        output tready
    );
endinterface

// File: rtl/hs_bus_amba_axis_w2mif_skid.sv
// Wire-to-interface AXI-Stream adapter with a 2-entry full-throughput register slice.
// Main register M drives the interface; skid register S absorbs the beat in flight on a stall.
module hs_bus_amba_axis_w2mif_skid #(
    parameter int TDATA_WIDTH = 8,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TSTRB_WIDTH = TDATA_WIDTH / 8,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [TSTRB_WIDTH-1:0] s_axis_tstrb,
    input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic [TID_WIDTH-1:0]   s_axis_tid,
    input  logic [TDEST_WIDTH-1:0] s_axis_tdest,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic                   s_axis_twakeup,
    output logic [1:0]             occupancy,
    hs_bus_amba_axis_if.master     m_axis_if
);
    localparam int PW = TDATA_WIDTH + TSTRB_WIDTH + TKEEP_WIDTH + 1
                      + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;

    // Encoding doubles as the occupancy count, so the state is observable directly.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] m_q, m_d;
    logic [PW-1:0] s_q, s_d;
    logic          ready_q, ready_d;
    logic          wake_q, wake_d;
    logic [PW-1:0] in_pl;
    logic          s_acc;
    logic          m_acc;

    assign in_pl = {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast,
                    s_axis_tid, s_axis_tdest, s_axis_tuser};
    assign s_acc = s_axis_tvalid & ready_q;
    assign m_acc = (state_q != ST_EMPTY) & m_axis_if.tready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (s_acc) begin
                    m_d     = in_pl;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (s_acc && m_acc) begin
                    m_d = in_pl;
                end else if (s_acc) begin
                    s_d     = in_pl;
                    state_d = ST_FULL;
                end else if (m_acc) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // Producer is held off here, so only the drain path applies.
                if (m_acc) begin
                    m_d     = s_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        ready_d = (state_d != ST_FULL);
        wake_d  = s_axis_twakeup | (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
            ready_q <= 1'b0;
            wake_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
            ready_q <= ready_d;
            wake_q  <= wake_d;
        end
    end

    assign s_axis_tready     = ready_q;
    assign occupancy         = state_q;
    assign m_axis_if.tvalid  = (state_q != ST_EMPTY);
    assign m_axis_if.twakeup = wake_q;
    assign {m_axis_if.tdata, m_axis_if.tstrb, m_axis_if.tkeep, m_axis_if.tlast,
            m_axis_if.tid, m_axis_if.tdest, m_axis_if.tuser} = m_q;
endmodule
